// File: rtl/scarv_soc_bram_initiator.sv
// Bridge from a req/gnt + recv/ack word port onto a single-port SoC BRAM.
// Requests inside the BASE/SIZE window drive the BRAM port in the accept
// cycle. The response (read data or error) is presented the following cycle
// and held until acked. Out-of-window requests never touch the BRAM and
// return an error response.
//
// Ports:
//   clka, rsta    clock, synchronous active-high reset
//   mem_req/gnt   request handshake (gnt is combinational)
//   mem_wen       1 = write, 0 = read
//   mem_strb      byte write strobes (writes only)
//   mem_addr      byte address, bits [1:0] ignored
//   mem_wdata     write data
//   mem_recv/ack  response handshake
//   mem_error     error flag, valid with mem_recv
//   mem_rdata     read data, valid with mem_recv
//   bram_*        native BRAM port, read data one cycle after bram_en
module scarv_soc_bram_initiator #(
    parameter logic [31:0] BASE = 32'h0000_0000,
    parameter int unsigned SIZE = 1024,
    parameter int unsigned AW   = 14
) (
    input  logic          clka,
    input  logic          rsta,
    input  logic          mem_req,
    output logic          mem_gnt,
    input  logic          mem_wen,
    input  logic [3:0]    mem_strb,
    input  logic [31:0]   mem_addr,
    input  logic [31:0]   mem_wdata,
    output logic          mem_recv,
    input  logic          mem_ack,
    output logic          mem_error,
    output logic [31:0]   mem_rdata,
    output logic          bram_en,
    output logic [3:0]    bram_we,
    output logic [AW-1:0] bram_addr,
    output logic [31:0]   bram_wdata,
    input  logic [31:0]   bram_rdata
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RSP  = 1'b1;

    logic [0:0]  state;
    logic [0:0]  state_nxt;
    logic        rsp_err;
    logic        rsp_err_nxt;
    logic        rsp_wr;
    logic        rsp_wr_nxt;

    logic        accept;
    logic        in_range;
    logic [32:0] addr_ext;
    logic [32:0] offset;

    // State and response-attribute registers.
    always_ff @(posedge clka) begin
        if (rsta) begin
            state   <= ST_IDLE;
            rsp_err <= 1'b0;
            rsp_wr  <= 1'b0;
        end else begin
            state   <= state_nxt;
            rsp_err <= rsp_err_nxt;
            rsp_wr  <= rsp_wr_nxt;
        end
    end

    // Next-state, handshake and BRAM port logic.
    always_comb begin
        state_nxt   = state;
        rsp_err_nxt = rsp_err;
        rsp_wr_nxt  = rsp_wr;
        mem_gnt     = 1'b0;
        accept      = 1'b0;
        bram_en     = 1'b0;
        bram_we     = 4'b0000;
        mem_recv    = 1'b0;
        mem_error   = 1'b0;
        mem_rdata   = 32'h0;

        // 33-bit window check so addresses near the top of the map cannot wrap.
        addr_ext = {1'b0, mem_addr};
        offset   = addr_ext - {1'b0, BASE};
        in_range = (addr_ext >= {1'b0, BASE}) && (offset < 33'(SIZE));

        // A new request may only replace a response that is being acked now.
        mem_gnt = mem_req && !rsta && ((state == ST_IDLE) || mem_ack);
        accept  = mem_req && mem_gnt;

        bram_en    = accept && in_range;
        bram_we    = (accept && in_range && mem_wen) ? mem_strb : 4'b0000;
        bram_addr  = {mem_addr[AW-1:2] - BASE[AW-1:2], 2'b00};
        bram_wdata = mem_wdata;

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_RSP;
                end
            end
            ST_RSP: begin
                if (mem_ack && !accept) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (accept) begin
            rsp_err_nxt = !in_range;
            rsp_wr_nxt  = mem_wen;
        end

        // BRAM is not re-enabled while stalled, so bram_rdata holds by itself.
        if (state == ST_RSP) begin
            mem_recv  = 1'b1;
            mem_error = rsp_err;
            mem_rdata = (!rsp_wr && !rsp_err) ? bram_rdata : 32'h0;
        end
    end

endmodule

// File: tb/tb_scarv_soc_bram_initiator.sv
// Self-checking bench for scarv_soc_bram_initiator (BASE=0x1000, SIZE=1024).
// A simple BRAM is modelled next to the DUT; a transaction-level reference
// model (reference memory + one pending response) predicts every output.
module tb_scarv_soc_bram_initiator;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int unsigned SIZE = 1024;
    localparam int unsigned AW   = 14;
    localparam int unsigned NW   = SIZE / 4;

    logic          clk = 1'b0;
    logic          rsta;
    logic          mem_req;
    logic          mem_gnt;
    logic          mem_wen;
    logic [3:0]    mem_strb;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_recv;
    logic          mem_ack;
    logic          mem_error;
    logic [31:0]   mem_rdata;
    logic          bram_en;
    logic [3:0]    bram_we;
    logic [AW-1:0] bram_addr;
    logic [31:0]   bram_wdata;
    logic [31:0]   bram_rdata = 32'h0;

    logic [31:0]   bmem    [NW] = '{default: 32'h0};
    logic [31:0]   ref_mem [NW] = '{default: 32'h0};

    int checks   = 0;
    int failures = 0;

    // Reference model: at most one response outstanding.
    logic        m_pend = 1'b0;
    logic        m_err  = 1'b0;
    logic        m_wr   = 1'b0;
    logic [31:0] m_data = 32'h0;

    // Observed outputs of the most recent step, for literal checks.
    logic          obs_gnt;
    logic          obs_en;
    logic [3:0]    obs_we;
    logic [AW-1:0] obs_addr;
    logic          obs_recv;
    logic          obs_err;
    logic [31:0]   obs_rdata;

    scarv_soc_bram_initiator #(
        .BASE (BASE),
        .SIZE (SIZE),
        .AW   (AW)
    ) dut (
        .clka       (clk),
        .rsta       (rsta),
        .mem_req    (mem_req),
        .mem_gnt    (mem_gnt),
        .mem_wen    (mem_wen),
        .mem_strb   (mem_strb),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_recv   (mem_recv),
        .mem_ack    (mem_ack),
        .mem_error  (mem_error),
        .mem_rdata  (mem_rdata),
        .bram_en    (bram_en),
        .bram_we    (bram_we),
        .bram_addr  (bram_addr),
        .bram_wdata (bram_wdata),
        .bram_rdata (bram_rdata)
    );

    always #5 clk = ~clk;

    // Single-port BRAM, read-first, one-cycle registered read.
    always_ff @(posedge clk) begin
        if (bram_en) begin
            for (int b = 0; b < 4; b++) begin
                if (bram_we[b]) begin
                    bmem[bram_addr[9:2]][8*b +: 8] <= bram_wdata[8*b +: 8];
                end
            end
            bram_rdata <= bmem[bram_addr[9:2]];
        end
    end

    function automatic logic in_win(input logic [31:0] a);
        longint unsigned la;
        longint unsigned lb;
        la = 64'(a);
        lb = 64'(BASE);
        return (la >= lb) && ((la - lb) < 64'(SIZE));
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'(((a - BASE) >> 2) & 32'(NW - 1));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive, compare against the model, then advance the model.
    task automatic step(input logic rst, input logic req, input logic wen,
                        input logic [3:0] strb, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic ack);
        logic          inr;
        logic          e_gnt;
        logic          e_en;
        logic [3:0]    e_we;
        logic [AW-1:0] e_addr;
        logic [31:0]   e_rdata;
        int            i;
        @(negedge clk);
        rsta      = rst;
        mem_req   = req;
        mem_wen   = wen;
        mem_strb  = strb;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_ack   = ack;
        #1;
        inr     = in_win(addr);
        e_gnt   = req && !rst && (!m_pend || ack);
        e_en    = e_gnt && inr;
        e_we    = (e_en && wen) ? strb : 4'b0000;
        e_addr  = AW'((addr - BASE) & 32'hFFFF_FFFC);
        e_rdata = (m_pend && !m_wr && !m_err) ? m_data : 32'h0;
        chk("mem_gnt",    32'(mem_gnt),    32'(e_gnt));
        chk("bram_en",    32'(bram_en),    32'(e_en));
        chk("bram_we",    32'(bram_we),    32'(e_we));
        chk("bram_addr",  32'(bram_addr),  32'(e_addr));
        chk("bram_wdata", bram_wdata,      wdata);
        chk("mem_recv",   32'(mem_recv),   32'(m_pend));
        chk("mem_error",  32'(mem_error),  32'(m_pend && m_err));
        chk("mem_rdata",  mem_rdata,       e_rdata);
        obs_gnt   = mem_gnt;
        obs_en    = bram_en;
        obs_we    = bram_we;
        obs_addr  = bram_addr;
        obs_recv  = mem_recv;
        obs_err   = mem_error;
        obs_rdata = mem_rdata;
        @(posedge clk);
        if (rst) begin
            m_pend = 1'b0;
        end else if (e_gnt) begin
            i      = widx(addr);
            m_pend = 1'b1;
            m_err  = !inr;
            m_wr   = wen;
            m_data = inr ? ref_mem[i] : 32'h0;
            if (inr && wen) begin
                for (int b = 0; b < 4; b++) begin
                    if (strb[b]) ref_mem[i][8*b +: 8] = wdata[8*b +: 8];
                end
            end
        end else if (m_pend && ack) begin
            m_pend = 1'b0;
        end
    endtask

    initial begin
        int n_gnt;
        logic [31:0] a;

        // Bring the DUT out of its power-up state before checking anything.
        rsta = 1'b1; mem_req = 1'b0; mem_wen = 1'b0; mem_strb = 4'h0;
        mem_addr = 32'h0; mem_wdata = 32'h0; mem_ack = 1'b0;
        @(posedge clk);

        // Reset with a request pending: nothing granted.
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 1'b1, 1'b0, 4'h0, 32'h0000_1000, 32'h0, 1'b0);
            chk("rst_gnt",  32'(obs_gnt),  32'h0);
            chk("rst_recv", 32'(obs_recv), 32'h0);
            chk("rst_en",   32'(obs_en),   32'h0);
        end

        // Full-word write then read back.
        step(1'b0, 1'b1, 1'b1, 4'hF, 32'h0000_1010, 32'hDEAD_BEEF, 1'b1);
        chk("wr_gnt",  32'(obs_gnt),  32'h1);
        chk("wr_we",   32'(obs_we),   32'hF);
        chk("wr_addr", 32'(obs_addr), 32'h10);
        step(1'b0, 1'b1, 1'b0, 4'h0, 32'h0000_1010, 32'h0, 1'b1);
        chk("wr_rsp_recv",  32'(obs_recv), 32'h1);
        chk("wr_rsp_rdata", obs_rdata,     32'h0);
        step(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
        chk("rd_rdata", obs_rdata,    32'hDEAD_BEEF);
        chk("rd_err",   32'(obs_err), 32'h0);

        // Single-byte strobe on an unaligned address.
        step(1'b0, 1'b1, 1'b1, 4'b0100, 32'h0000_1023, 32'h1122_3344, 1'b1);
        chk("strb_addr", 32'(obs_addr), 32'h20);
        chk("strb_we",   32'(obs_we),   32'h4);
        step(1'b0, 1'b1, 1'b0, 4'h0, 32'h0000_1020, 32'h0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
        chk("strb_rdata", obs_rdata, 32'h0022_0000);

        // Window boundaries.
        step(1'b0, 1'b1, 1'b0, 4'h0, 32'h0000_1400, 32'h0, 1'b1);
        chk("oor_rd_en", 32'(obs_en), 32'h0);
        step(1'b0, 1'b1, 1'b1, 4'hF, 32'h0000_0FFC, 32'hFFFF_FFFF, 1'b1);
        chk("oor_wr_en",    32'(obs_en),   32'h0);
        chk("oor_rd_err",   32'(obs_err),  32'h1);
        chk("oor_rd_rdata", obs_rdata,     32'h0);
        step(1'b0, 1'b1, 1'b0, 4'h0, 32'h0000_13FC, 32'h0, 1'b1);
        chk("top_en",     32'(obs_en),   32'h1);
        chk("top_addr",   32'(obs_addr), 32'h3FC);
        chk("oor_wr_err", 32'(obs_err),  32'h1);
        step(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
        chk("top_err", 32'(obs_err), 32'h0);

        // Backpressure: response held, no new grant until ack.
        step(1'b0, 1'b1, 1'b0, 4'h0, 32'h0000_1010, 32'h0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1, 1'b0, 4'h0, 32'h0000_1020, 32'h0, 1'b0);
            chk("bp_gnt",   32'(obs_gnt), 32'h0);
            chk("bp_en",    32'(obs_en),  32'h0);
            chk("bp_rdata", obs_rdata,    32'hDEAD_BEEF);
        end
        step(1'b0, 1'b1, 1'b0, 4'h0, 32'h0000_1020, 32'h0, 1'b1);
        chk("bp_rel_gnt",   32'(obs_gnt), 32'h1);
        chk("bp_rel_rdata", obs_rdata,    32'hDEAD_BEEF);
        step(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
        chk("bp_next_rdata", obs_rdata, 32'h0022_0000);

        // Back-to-back writes then reads at full rate.
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b1, 1'b1, 4'hF, BASE + 32'h100 + 32'(4*k), 32'hA000_0000 + 32'(k), 1'b1);
        end
        n_gnt = 0;
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b1, 1'b0, 4'h0, BASE + 32'h100 + 32'(4*k), 32'h0, 1'b1);
            if (obs_gnt) n_gnt++;
            if (k > 0) chk("b2b_rdata", obs_rdata, 32'hA000_0000 + 32'(k - 1));
        end
        chk("b2b_grants", 32'(n_gnt), 32'd8);
        step(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
        chk("b2b_last", obs_rdata, 32'hA000_0007);

        // Reset in the middle of a burst drops the response.
        step(1'b0, 1'b1, 1'b0, 4'h0, BASE + 32'h100, 32'h0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 4'h0, BASE + 32'h104, 32'h0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 4'h0, BASE + 32'h108, 32'h0, 1'b1);
        chk("mid_rst_gnt", 32'(obs_gnt), 32'h0);
        step(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
        chk("mid_rst_recv", 32'(obs_recv), 32'h0);

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(15) == 0) a = $urandom();
            else a = BASE - 32'd64 + 32'($urandom_range(SIZE + 127));
            step(($urandom_range(63) == 0),
                 ($urandom_range(3) != 0),
                 1'($urandom_range(1)),
                 4'($urandom_range(15)),
                 a,
                 $urandom(),
                 ($urandom_range(9) < 7));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/scarv_soc_bram_initiator.md
Name: scarv_soc_bram_initiator

Overview:
- Initiator-side bridge: accepts word requests from a core/interconnect port using a req/gnt request channel and a recv/ack response channel.
- Drives the native port of a single-port SoC BRAM: enable, byte write strobes, word address, write data; receives read data with 1-cycle latency.
- Performs address-window checking and returns errors without touching the BRAM.
- Supports back-to-back transactions at one per cycle when the response channel is not stalled.

Parameters:
- BASE, 32'h0000_0000, byte base address of the BRAM window.
- SIZE, 1024, window size in bytes; power of two, 4 to 16384.
- AW, 14, BRAM byte-address width driven on bram_addr.

Ports:
- clka  in  1  clock; all logic on rising edge.
- rsta  in  1  synchronous reset, active-high.
- mem_req  in  1  request valid.
- mem_gnt  out  1  request accepted this cycle.
- mem_wen  in  1  1=write, 0=read.
- mem_strb  in  4  byte write strobes; ignored for reads.
- mem_addr  in  32  byte address; bits [1:0] ignored.
- mem_wdata  in  32  write data.
- mem_recv  out  1  response valid.
- mem_ack  in  1  response accepted by requester.
- mem_error  out  1  response is an error; valid with mem_recv.
- mem_rdata  out  32  read data; valid with mem_recv.
- bram_en  out  1  BRAM enable.
- bram_we  out  4  BRAM byte write enables.
- bram_addr  out  AW  BRAM byte address, word aligned.
- bram_wdata  out  32  BRAM write data.
- bram_rdata  in  32  BRAM registered read data, valid the cycle after bram_en.

Behaviour:
- States: IDLE (no response outstanding), RSP (response presented on mem_recv).
- Reset (rsta=1 at edge): state=IDLE; rsp_err=0; rsp_wr=0. Reset overrides any in-flight transaction; a pending response is dropped.
- Outputs while in reset and IDLE: mem_gnt follows the rule below; mem_recv=0, mem_error=0, mem_rdata=0.
- in_range = (mem_addr >= BASE) && (mem_addr - BASE < SIZE), evaluated in 33-bit arithmetic with no wrap.
- mem_gnt = mem_req && !rsta && (state==IDLE || (state==RSP && mem_ack)). Combinational; no dependency on mem_recv of the next cycle.
- Accept = mem_req && mem_gnt.
- bram_en = accept && in_range.
- bram_we = (accept && in_range && mem_wen) ? mem_strb : 4'b0.
- bram_addr = {mem_addr[AW-1:2] - BASE[AW-1:2], 2'b00}, i.e. the offset within the window, low 2 bits forced 0.
- bram_wdata = mem_wdata, unconditionally.
- On accept: next state=RSP; rsp_err<=!in_range; rsp_wr<=mem_wen.
- In RSP: mem_ack && !accept -> IDLE. Otherwise remain in RSP (new response loaded if accept).
- Response latency: exactly 1 cycle after accept; mem_recv=1 whenever state==RSP.
- mem_error = (state==RSP) && rsp_err.
- mem_rdata = (state==RSP && !rsp_wr && !rsp_err) ? bram_rdata : 0.
- Stall hold: while RSP && !mem_ack, mem_gnt=0, so bram_en=0 and the BRAM holds bram_rdata. mem_recv, mem_error and mem_rdata stay stable until acked; no data buffer is required.
- Write with mem_strb=0: accepted, bram_en=1, bram_we=0, normal success response.
- Out-of-range request: bram_en=0 and no BRAM side effect; error response with rdata=0, read or write.
- mem_ack while state==IDLE: ignored.
- Throughput: 1 transaction/cycle with mem_ack held high and mem_req continuous.

Test Plan:
- Reset then idle: rsta=1 for 2 cycles with mem_req=1 -> mem_gnt=0, mem_recv=0, bram_en=0. After release, the first req is granted the same cycle.
- Write then read, BASE=0: write addr 0x10, strb=4'b1111, data 0xDEADBEEF; then read 0x10 -> bram_we=4'hF, bram_addr=0x10 on the write. Read mem_recv 1 cycle after gnt with mem_rdata=0xDEADBEEF, mem_error=0. Write response rdata=0.
- Byte strobe: write 0x11223344 to 0x20 with strb=4'b0100 over an initial 0x0 -> later read of 0x20 returns 0x00220000. An address of 0x23 gives bram_addr=0x20.
- Out of range: BASE=0x1000, SIZE=1024, read 0x1400 and write 0x0FFC -> bram_en=0 both times. Responses have mem_error=1, mem_rdata=0, and the BRAM is unchanged. Read of 0x13FC succeeds with bram_addr=0x3FC.
- Backpressure: a read is accepted, then mem_ack=0 for 3 cycles with mem_req=1 -> mem_gnt=0, bram_en=0, and mem_rdata stable for 3 cycles. On mem_ack=1, the new request is granted the same cycle and its response appears the next cycle.
- Back-to-back: 8 consecutive reads with mem_ack=1 constantly -> 8 grants in 8 cycles and 8 responses in the following 8 cycles, in order with correct data. Asserting rsta mid-burst -> mem_recv=0 the next cycle and state=IDLE.
